// File: rtl/mul_if.sv
// mul_if: request/result bundle between the issue stage and the mul_unit.
// The master side issues requests and consumes the product write-back;
// the slave side is the multiplier itself.
interface mul_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] op0;
    logic [WIDTH-1:0] op1;
    logic [2:0]       dest_in;
    logic             sgn;
    logic [WIDTH-1:0] w_in;
    logic [2:0]       DEST;
    logic             w_en;
    logic [WIDTH-1:0] hi;
    logic             busy;

    modport master (
        output start, op0, op1, dest_in, sgn,
        input  w_in, DEST, w_en, hi, busy
    );

    modport slave (
        input  start, op0, op1, dest_in, sgn,
        output w_in, DEST, w_en, hi, busy
    );
endinterface

// File: rtl/mul_unit.sv
// mul_unit: fixed-latency radix-2 shift-add multiplier.
// A request captured in IDLE runs WIDTH iterations (one multiplier bit per
// clock, LSB first) and then spends one DONE cycle with w_en high, so the
// write strobe always lands 16 edges after the capture edge.
// Optional feature macro: MUL_SIGNED_EN. When defined, sgn=1 selects a
// two's-complement multiply (magnitudes multiplied, product negated when the
// operand signs differ). When undefined, every multiply is unsigned.
module mul_unit #(
    parameter int WIDTH = 16
) (
    input  logic  clk,
    input  logic  reset,
    mul_if.slave  bus
);

    localparam int PW = 2 * WIDTH;
    localparam logic [4:0]       LAST_ITER = 5'(WIDTH - 1);
    localparam logic [PW-1:0]    ZERO_P    = {PW{1'b0}};
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       cnt_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [2:0]       dest_q;
    logic [WIDTH-1:0] w_in_q;
    logic [WIDTH-1:0] hi_q;
    logic [2:0]       dest_out_q;
    logic             w_en_q;
    logic             busy_q;

    logic [PW-1:0]    addend_s;
    logic [PW-1:0]    acc_sum_s;
    logic [PW-1:0]    product_s;
    logic [WIDTH-1:0] cap_mcand_s;
    logic [WIDTH-1:0] cap_mplier_s;

`ifdef MUL_SIGNED_EN
    logic neg_q;
    logic cap_neg_s;

    // Magnitude of a two's-complement word when it is to be treated as signed.
    function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v,
                                               input logic             is_signed);
        logic [WIDTH-1:0] r;
        if (is_signed && v[WIDTH-1]) begin
            r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two's-complement negation of the full-width product.
    function automatic logic [PW-1:0] neg_f(input logic [PW-1:0] v);
        return ~v + {{(PW-1){1'b0}}, 1'b1};
    endfunction

    // Operand conditioning at capture: magnitudes plus the final sign.
    always_comb begin
        cap_mcand_s  = mag_f(bus.op0, bus.sgn);
        cap_mplier_s = mag_f(bus.op1, bus.sgn);
        cap_neg_s    = bus.sgn & (bus.op0[WIDTH-1] ^ bus.op1[WIDTH-1]);
    end

    // Sign fix-up of the finished magnitude product.
    always_comb begin
        if (neg_q) begin
            product_s = neg_f(acc_sum_s);
        end else begin
            product_s = acc_sum_s;
        end
    end
`else
    // Unsigned-only build: operands are used exactly as captured.
    always_comb begin
        cap_mcand_s  = bus.op0;
        cap_mplier_s = bus.op1;
    end

    // Unsigned-only build: the accumulated sum is the product.
    always_comb begin
        product_s = acc_sum_s;
    end
`endif

    // Partial-product add for the current multiplier bit.
    always_comb begin
        if (mplier_q[0]) begin
            addend_s = mcand_q;
        end else begin
            addend_s = ZERO_P;
        end
        acc_sum_s = acc_q + addend_s;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start only matters in IDLE; RUN ends on the last bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs: capture, iterate, publish, strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= 5'd0;
            acc_q      <= ZERO_P;
            mcand_q    <= ZERO_P;
            mplier_q   <= ZERO_W;
            dest_q     <= 3'd0;
            w_in_q     <= ZERO_W;
            hi_q       <= ZERO_W;
            dest_out_q <= 3'd0;
            w_en_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef MUL_SIGNED_EN
            neg_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    w_en_q <= 1'b0;
                    if (bus.start) begin
                        cnt_q    <= 5'd0;
                        acc_q    <= ZERO_P;
                        mcand_q  <= {ZERO_W, cap_mcand_s};
                        mplier_q <= cap_mplier_s;
                        dest_q   <= bus.dest_in;
                        busy_q   <= 1'b1;
`ifdef MUL_SIGNED_EN
                        neg_q    <= cap_neg_s;
`endif
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    acc_q    <= acc_sum_s;
                    mcand_q  <= {mcand_q[PW-2:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER) begin
                        w_in_q     <= product_s[WIDTH-1:0];
                        hi_q       <= product_s[PW-1:WIDTH];
                        dest_out_q <= dest_q;
                        w_en_q     <= 1'b1;
                    end else begin
                        w_en_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    w_en_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    w_en_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.w_in = w_in_q;
    assign bus.hi   = hi_q;
    assign bus.DEST = dest_out_q;
    assign bus.w_en = w_en_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed, table-driven bench for mul_unit, plus hand-written
// sequences for start-while-busy, mid-operation reset and back-to-back issue.
module tb_mul_unit;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mul_if #(.WIDTH(16)) bus ();

    mul_unit #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [2:0]  d;
        logic [31:0] exp_u;   // product when the signed feature is absent
        logic [31:0] exp_s;   // product when the signed feature is built in
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller is positioned just after a falling edge; the next rising edge is k.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic [2:0] d, output int lat, output int pulses,
                          output logic [15:0] lo, output logic [15:0] hw,
                          output logic [2:0] dst, output int busy_n);
        lat = 0; pulses = 0; busy_n = 0; lo = 16'h0; hw = 16'h0; dst = 3'd0;
        bus.op0 = a; bus.op1 = b; bus.sgn = s; bus.dest_in = d; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.op0     = 16'($urandom);
        bus.op1     = 16'($urandom);
        bus.sgn     = ~s;
        bus.dest_in = ~d;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy) busy_n++;
            if (bus.w_en) begin
                pulses++;
                if (lat == 0) lat = i;
                lo  = bus.w_in;
                hw  = bus.hi;
                dst = bus.DEST;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat, pulses, busy_n, last_busy, first_idx, last_idx, consec;
        logic [15:0] lo, hw;
        logic [2:0]  dst;
        logic        prev_wen;
        logic [31:0] exp;

        n_checks = 0;
        n_errors = 0;

        //               a         b         s     d     unsigned       signed
        vecs[0] = '{16'h0003, 16'h0005, 1'b0, 3'd2, 32'h0000000F, 32'h0000000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 3'd7, 32'hFFFE0001, 32'hFFFE0001};
        vecs[2] = '{16'hFFFE, 16'h0003, 1'b1, 3'd3, 32'h0002FFFA, 32'hFFFFFFFA};
        vecs[3] = '{16'h1234, 16'h0010, 1'b0, 3'd4, 32'h00012340, 32'h00012340};
        vecs[4] = '{16'h8000, 16'h8000, 1'b1, 3'd5, 32'h40000000, 32'h40000000};
        vecs[5] = '{16'h0007, 16'hFFF9, 1'b1, 3'd6, 32'h0006FFCF, 32'hFFFFFFCF};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 3'd1, 32'hFFFE0001, 32'h00000001};
        vecs[7] = '{16'h0000, 16'hABCD, 1'b0, 3'd0, 32'h00000000, 32'h00000000};
        vecs[8] = '{16'h00FF, 16'h0101, 1'b0, 3'd2, 32'h0000FFFF, 32'h0000FFFF};

        reset = 1'b0;
        bus.start = 1'b0; bus.op0 = 16'h0; bus.op1 = 16'h0; bus.sgn = 1'b0; bus.dest_in = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_w_in", 32'(bus.w_in), 32'h0);
        check("reset_hi",   32'(bus.hi),   32'h0);
        check("reset_DEST", 32'(bus.DEST), 32'h0);
        check("reset_w_en", 32'(bus.w_en), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);

        // Release reset and request on the very first active edge.
        @(negedge clk);
        reset = 1'b1;
        for (int v = 0; v < 9; v++) begin
            if (v != 0) @(negedge clk);
`ifdef MUL_SIGNED_EN
            exp = vecs[v].exp_s;
`else
            exp = vecs[v].exp_u;
`endif
            run_op(vecs[v].a, vecs[v].b, vecs[v].s, vecs[v].d, lat, pulses, lo, hw, dst, busy_n);
            check($sformatf("v%0d_latency", v), 32'(lat),    32'd16);
            check($sformatf("v%0d_pulses", v),  32'(pulses), 32'd1);
            check($sformatf("v%0d_w_in", v),    32'(lo),     32'(exp[15:0]));
            check($sformatf("v%0d_hi", v),      32'(hw),     32'(exp[31:16]));
            check($sformatf("v%0d_DEST", v),    32'(dst),    32'(vecs[v].d));
            check($sformatf("v%0d_busy", v),    32'(busy_n), 32'd16);
        end

        // start re-asserted across edges k+5 and k+16/k+17 must be ignored.
        @(negedge clk);
        bus.op0 = 16'h0002; bus.op1 = 16'h0002; bus.sgn = 1'b0; bus.dest_in = 3'd6; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        pulses = 0; busy_n = 0; last_busy = 0; lo = 16'h0; hw = 16'hFFFF; dst = 3'd0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy) begin busy_n++; last_busy = i; end
            if (bus.w_en) begin pulses++; lo = bus.w_in; hw = bus.hi; dst = bus.DEST; end
            if (i == 4)  begin bus.start = 1'b1; bus.op0 = 16'h0007; bus.op1 = 16'h0007; end
            if (i == 5)  bus.start = 1'b0;
            if (i == 15) bus.start = 1'b1;
            if (i == 17) bus.start = 1'b0;
        end
        check("busy_ign_pulses",    32'(pulses),    32'd1);
        check("busy_ign_w_in",      32'(lo),        32'h4);
        check("busy_ign_hi",        32'(hw),        32'h0);
        check("busy_ign_DEST",      32'(dst),       32'd6);
        check("busy_ign_busy_n",    32'(busy_n),    32'd16);
        check("busy_ign_last_busy", 32'(last_busy), 32'd16);

        // Reset between edges k+8 and k+9 aborts the operation.
        @(negedge clk);
        bus.op0 = 16'h1234; bus.op1 = 16'h0056; bus.sgn = 1'b0; bus.dest_in = 3'd5; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_w_in", 32'(bus.w_in), 32'h0);
        check("abort_hi",   32'(bus.hi),   32'h0);
        check("abort_DEST", 32'(bus.DEST), 32'h0);
        check("abort_w_en", 32'(bus.w_en), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.w_en) pulses++;
        end
        check("abort_no_wen", 32'(pulses), 32'd0);
        @(negedge clk);
        run_op(16'h0003, 16'h0005, 1'b0, 3'd2, lat, pulses, lo, hw, dst, busy_n);
        check("post_abort_latency", 32'(lat),    32'd16);
        check("post_abort_pulses",  32'(pulses), 32'd1);
        check("post_abort_w_in",    32'(lo),     32'h000F);
        check("post_abort_hi",      32'(hw),     32'h0000);
        check("post_abort_DEST",    32'(dst),    32'd2);

        // start held high: one result every 18 cycles, never adjacent strobes.
        @(negedge clk);
        bus.op0 = 16'h0010; bus.op1 = 16'h0010; bus.sgn = 1'b0; bus.dest_in = 3'd1; bus.start = 1'b1;
        pulses = 0; first_idx = -1; last_idx = -1; consec = 0; prev_wen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.w_en) begin
                pulses++;
                if (first_idx < 0) first_idx = i;
                last_idx = i;
                if (prev_wen) consec++;
                check($sformatf("b2b_w_in_%0d", i), 32'(bus.w_in), 32'h0100);
            end
            prev_wen = bus.w_en;
        end
        bus.start = 1'b0;
        check("b2b_pulses", 32'(pulses),             32'd3);
        check("b2b_first",  32'(first_idx),          32'd16);
        check("b2b_span",   32'(last_idx - first_idx), 32'd36);
        check("b2b_consec", 32'(consec),             32'd0);
        repeat (20) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
